// File: rtl/nonce_report_tx.sv
// nonce_report_tx: buffers golden nonces in a small FIFO and sends each one
// to the host as four 8N1 UART bytes, least-significant byte first.
module nonce_report_tx #(
  parameter logic [15:0] BAUD_DIV   = 16'd434,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nonce_in,
  input  logic        nonce_valid,
  output logic        txd,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state;
  logic [31:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [15:0]         baud_cnt;
  logic [2:0]          bit_cnt;
  logic [1:0]          byte_cnt;
  logic [31:0]         shreg;
  logic [7:0]          cur_byte;
  logic                empty;
  logic                full;
  logic                pop;
  logic                push;
  logic                baud_end;

  // A pop on the same edge frees a slot, so a push into a full FIFO is legal then.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
               (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    pop      = (state == IDLE) && !empty;
    push     = nonce_valid && (!full || pop);
    baud_end = (baud_cnt == BAUD_DIV - 16'd1);
    busy     = !empty || (state != IDLE);
    cur_byte = shreg[7:0];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= nonce_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (nonce_valid && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // txd is registered from the next-state decision, so the start bit appears
  // on the same edge that pops the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shreg    <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            byte_cnt <= '0;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              txd     <= cur_byte[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_cnt != 2'd3) begin
              byte_cnt <= byte_cnt + 2'd1;
              shreg    <= shreg >> 8;
              txd      <= 1'b0;
              state    <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
